hazard_scoreboard: RTL and testbench

- Parametrised successor to the pipeline's load-use/branch hazard unit.
- Tracks in-flight register writes for every producer class in a per-register scoreboard:
  - ALU: forwarded, no stall.
  - Load and multiply: fixed latency.
  - Divide: variable latency, done handshake.
- Generates stall/bubble controls for PC, F, D, E and M.
- Sits beside the decode stage; sees the instruction in D and redirect/completion events from later stages.

---
 rtl/hazard_scoreboard.sv | 160 ++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Decode-side hazard unit: per-register in-flight write scoreboard with
// fixed-latency (load/mul) countdowns and a single variable-latency divide slot.
module hazard_scoreboard #(
    parameter int unsigned NREG     = 32,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned MUL_LAT  = 3,
    parameter int unsigned CNT_W    = 4,
    parameter int unsigned PERF_W   = 32,
    localparam int unsigned RW      = $clog2(NREG)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              D_valid_i,
    input  logic [RW-1:0]     D_rs1_i,
    input  logic [RW-1:0]     D_rs2_i,
    input  logic              D_use_rs1_i,
    input  logic              D_use_rs2_i,
    input  logic [RW-1:0]     D_rd_i,
    input  logic              D_need_dst_i,
    input  logic [1:0]        D_class_i,
    input  logic              E_redirect_i,
    input  logic              div_done_i,
    output logic              PC_stall_o,
    output logic              F_stall_o,
    output logic              F_bubble_o,
    output logic              D_stall_o,
    output logic              D_bubble_o,
    output logic              E_stall_o,
    output logic              E_bubble_o,
    output logic              M_stall_o,
    output logic              M_bubble_o,
    output logic              div_busy_o,
    output logic [PERF_W-1:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        CLS_ALU  = 2'd0,
        CLS_LOAD = 2'd1,
        CLS_MUL  = 2'd2,
        CLS_DIV  = 2'd3
    } cls_e;

    logic [NREG-1:0]   pend_q, pend_d;
    logic [NREG-1:0]   isdiv_q, isdiv_d;
    logic [CNT_W-1:0]  cnt_q [NREG];
    logic [CNT_W-1:0]  cnt_d [NREG];
    logic              div_busy_q, div_busy_d;
    logic [RW-1:0]     div_rd_q, div_rd_d;
    logic [PERF_W-1:0] stall_cnt_q;

    logic raw, struct_hz, hz, issue, stall_cycle;
    cls_e cls;

    // Hazard detection and pipeline control, purely combinational.
    always_comb begin
        cls         = cls_e'(D_class_i);
        raw         = D_valid_i &
                      ((D_use_rs1_i & (D_rs1_i != '0) & pend_q[D_rs1_i]) |
                       (D_use_rs2_i & (D_rs2_i != '0) & pend_q[D_rs2_i]));
        struct_hz   = D_valid_i & (cls == CLS_DIV) & div_busy_q;
        hz          = raw | struct_hz;
        issue       = D_valid_i & ~hz & ~E_redirect_i;
        stall_cycle = hz & ~E_redirect_i;
    end

    assign PC_stall_o  = stall_cycle;
    assign F_stall_o   = stall_cycle;
    assign F_bubble_o  = E_redirect_i;
    assign D_bubble_o  = hz | E_redirect_i;
    assign D_stall_o   = 1'b0;
    assign E_stall_o   = 1'b0;
    assign E_bubble_o  = 1'b0;
    assign M_stall_o   = 1'b0;
    assign M_bubble_o  = 1'b0;
    assign div_busy_o  = div_busy_q;
    assign stall_cnt_o = stall_cnt_q;

    // Scoreboard next state: countdown, then divide completion, then a new
    // issue last so it overrides both for the same destination.
    always_comb begin
        pend_d     = pend_q;
        isdiv_d    = isdiv_q;
        cnt_d      = cnt_q;
        div_busy_d = div_busy_q;
        div_rd_d   = div_rd_q;

        for (int unsigned r = 1; r < NREG; r++) begin
            if (pend_q[RW'(r)] && !isdiv_q[RW'(r)]) begin
                if (cnt_q[RW'(r)] > CNT_W'(1))
                    cnt_d[RW'(r)] = cnt_q[RW'(r)] - CNT_W'(1);
                else
                    pend_d[RW'(r)] = 1'b0;
            end
        end

        // Only clear the entry if no younger writer has claimed it since.
        if (div_done_i && div_busy_q) begin
            div_busy_d = 1'b0;
            if (isdiv_q[div_rd_q]) begin
                pend_d[div_rd_q]  = 1'b0;
                isdiv_d[div_rd_q] = 1'b0;
            end
        end

        if (issue && D_need_dst_i && (D_rd_i != '0)) begin
            case (cls)
                CLS_ALU: begin
                    pend_d[D_rd_i]  = 1'b0;
                    isdiv_d[D_rd_i] = 1'b0;
                end
                CLS_LOAD: begin
                    pend_d[D_rd_i]  = 1'b1;
                    isdiv_d[D_rd_i] = 1'b0;
                    cnt_d[D_rd_i]   = CNT_W'(LOAD_LAT);
                end
                CLS_MUL: begin
                    pend_d[D_rd_i]  = 1'b1;
                    isdiv_d[D_rd_i] = 1'b0;
                    cnt_d[D_rd_i]   = CNT_W'(MUL_LAT);
                end
                default: begin
                    pend_d[D_rd_i]  = 1'b1;
                    isdiv_d[D_rd_i] = 1'b1;
                    div_busy_d      = 1'b1;
                    div_rd_d        = D_rd_i;
                end
            endcase
        end

        pend_d[0]  = 1'b0;
        isdiv_d[0] = 1'b0;
        cnt_d[0]   = '0;
    end

    // Scoreboard and divide-slot registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pend_q     <= '0;
            isdiv_q    <= '0;
            cnt_q      <= '{default: '0};
            div_busy_q <= 1'b0;
            div_rd_q   <= '0;
        end else begin
            pend_q     <= pend_d;
            isdiv_q    <= isdiv_d;
            cnt_q      <= cnt_d;
            div_busy_q <= div_busy_d;
            div_rd_q   <= div_rd_d;
        end
    end

    // Saturating count of cycles lost to hazards (redirect cycles excluded).
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            stall_cnt_q <= '0;
        else if (stall_cycle && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + PERF_W'(1);
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: inputs change on the falling edge,
// outputs are checked 1 time unit later, well away from the rising edge.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        d_valid, d_use1, d_use2, d_need, redir, done;
    logic [4:0]  d_rs1, d_rs2, d_rd;
    logic [1:0]  d_cls;
    logic        pc_stall, f_stall, f_bubble, d_stall, d_bubble;
    logic        e_stall, e_bubble, m_stall, m_bubble, div_busy;
    logic [31:0] stall_cnt;

    int tests = 0;
    int fails = 0;

    localparam logic [1:0] ALU = 2'd0, LD = 2'd1, MUL = 2'd2, DIV = 2'd3;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .NREG(32), .LOAD_LAT(1), .MUL_LAT(3), .CNT_W(4), .PERF_W(32)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .D_valid_i(d_valid), .D_rs1_i(d_rs1), .D_rs2_i(d_rs2),
        .D_use_rs1_i(d_use1), .D_use_rs2_i(d_use2),
        .D_rd_i(d_rd), .D_need_dst_i(d_need), .D_class_i(d_cls),
        .E_redirect_i(redir), .div_done_i(done),
        .PC_stall_o(pc_stall), .F_stall_o(f_stall), .F_bubble_o(f_bubble),
        .D_stall_o(d_stall), .D_bubble_o(d_bubble),
        .E_stall_o(e_stall), .E_bubble_o(e_bubble),
        .M_stall_o(m_stall), .M_bubble_o(m_bubble),
        .div_busy_o(div_busy), .stall_cnt_o(stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Checks the four redirect/stall controls as one group.
    task automatic chk_ctl(input string tag, input logic stall, input logic fbub, input logic dbub);
        chk({tag, ".pc_stall"}, {31'd0, pc_stall}, {31'd0, stall});
        chk({tag, ".f_stall"},  {31'd0, f_stall},  {31'd0, stall});
        chk({tag, ".f_bubble"}, {31'd0, f_bubble}, {31'd0, fbub});
        chk({tag, ".d_bubble"}, {31'd0, d_bubble}, {31'd0, dbub});
    endtask

    // Advance to the next falling edge and present a D-stage instruction.
    task automatic step(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                        input logic need, input logic [1:0] cls,
                        input logic rd_redir, input logic dn);
        @(negedge clk);
        d_valid = v; d_rs1 = rs1; d_use1 = u1; d_rs2 = rs2; d_use2 = u2;
        d_rd = rd; d_need = need; d_cls = cls; redir = rd_redir; done = dn;
        #1;
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, ALU, 1'b0, 1'b0);
    endtask

    // Non-writing instruction reading rs1.
    task automatic reader(input logic [4:0] rs1, input logic dn);
        step(1'b1, rs1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, ALU, 1'b0, dn);
    endtask

    task automatic writer(input logic [4:0] rd, input logic [1:0] cls);
        step(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, rd, 1'b1, cls, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        d_valid = 1'b0; d_rs1 = '0; d_rs2 = '0; d_use1 = 1'b0; d_use2 = 1'b0;
        d_rd = '0; d_need = 1'b0; d_cls = ALU; redir = 1'b0; done = 1'b0;
        #1;
        chk_ctl("reset", 1'b0, 1'b0, 1'b0);
        chk("reset.stall_cnt", stall_cnt, 32'd0);
        chk("reset.div_busy", {31'd0, div_busy}, 32'd0);
        chk("reset.consts", {27'd0, d_stall, e_stall, e_bubble, m_stall, m_bubble}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Load x5 then dependent reader: exactly one stall cycle.
        writer(5'd5, LD);
        chk_ctl("ld.issue", 1'b0, 1'b0, 1'b0);
        reader(5'd5, 1'b0);
        chk_ctl("ld.use_stall", 1'b1, 1'b0, 1'b1);
        reader(5'd5, 1'b0);
        chk_ctl("ld.use_go", 1'b0, 1'b0, 1'b0);
        chk("ld.stall_cnt", stall_cnt, 32'd1);

        // MUL x7 then dependent reader: three stall cycles.
        writer(5'd7, MUL);
        chk_ctl("mul.issue", 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            reader(5'd7, 1'b0);
            chk_ctl("mul.use_stall", 1'b1, 1'b0, 1'b1);
        end
        reader(5'd7, 1'b0);
        chk_ctl("mul.use_go", 1'b0, 1'b0, 1'b0);
        chk("mul.stall_cnt", stall_cnt, 32'd4);

        // MUL x7 then unrelated reader of x8: no stall.
        writer(5'd7, MUL);
        reader(5'd8, 1'b0);
        chk_ctl("mul.indep", 1'b0, 1'b0, 1'b0);
        idle(); idle(); idle();
        chk("mul.indep_cnt", stall_cnt, 32'd4);

        // DIV x9, done 20 cycles later; reader unstalls the cycle after done.
        writer(5'd9, DIV);
        chk("div.busy_pre", {31'd0, div_busy}, 32'd0);
        for (int i = 0; i < 19; i++) begin
            reader(5'd9, 1'b0);
            chk_ctl("div.wait", 1'b1, 1'b0, 1'b1);
        end
        chk("div.busy", {31'd0, div_busy}, 32'd1);
        reader(5'd9, 1'b1);
        chk_ctl("div.done_cycle", 1'b1, 1'b0, 1'b1);
        reader(5'd9, 1'b0);
        chk_ctl("div.after_done", 1'b0, 1'b0, 1'b0);
        chk("div.busy_clr", {31'd0, div_busy}, 32'd0);
        chk("div.stall_cnt", stall_cnt, 32'd24);

        // Back-to-back divides: structural stall through the done cycle.
        writer(5'd9, DIV);
        writer(5'd10, DIV);
        chk_ctl("div.struct", 1'b1, 1'b0, 1'b1);
        step(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, DIV, 1'b0, 1'b1);
        chk_ctl("div.struct_done", 1'b1, 1'b0, 1'b1);
        writer(5'd10, DIV);
        chk_ctl("div.struct_go", 1'b0, 1'b0, 1'b0);
        step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, ALU, 1'b0, 1'b1);
        chk("div.struct_cnt", stall_cnt, 32'd26);
        reader(5'd10, 1'b0);
        chk_ctl("div.x10_free", 1'b0, 1'b0, 1'b0);

        // DIV x9 overwritten by younger ALU x9: readers never stall.
        writer(5'd9, DIV);
        writer(5'd9, ALU);
        chk_ctl("waw.alu_issue", 1'b0, 1'b0, 1'b0);
        reader(5'd9, 1'b0);
        chk_ctl("waw.read", 1'b0, 1'b0, 1'b0);
        chk("waw.busy", {31'd0, div_busy}, 32'd1);
        reader(5'd9, 1'b1);
        chk_ctl("waw.read_done", 1'b0, 1'b0, 1'b0);
        reader(5'd9, 1'b0);
        chk_ctl("waw.read_after", 1'b0, 1'b0, 1'b0);
        chk("waw.busy_clr", {31'd0, div_busy}, 32'd0);

        // RAW stall coincident with redirect: squash wins, nothing recorded.
        writer(5'd11, MUL);
        step(1'b1, 5'd11, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, LD, 1'b1, 1'b0);
        chk_ctl("redir.raw", 1'b0, 1'b1, 1'b1);
        reader(5'd12, 1'b0);
        chk_ctl("redir.no_update", 1'b0, 1'b0, 1'b0);
        chk("redir.stall_cnt", stall_cnt, 32'd26);
        idle(); idle();

        // Writes to x0 are never tracked.
        writer(5'd0, LD);
        step(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, ALU, 1'b0, 1'b0);
        chk_ctl("x0.read", 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a MUL countdown with a divide in flight.
        writer(5'd14, DIV);
        writer(5'd13, MUL);
        reader(5'd13, 1'b0);
        chk_ctl("rst.pre_stall", 1'b1, 1'b0, 1'b1);
        chk("rst.pre_busy", {31'd0, div_busy}, 32'd1);
        @(negedge clk);
        chk("rst.pre_cnt", stall_cnt, 32'd27);
        rst_n = 1'b0;
        #1;
        chk_ctl("rst.mid", 1'b0, 1'b0, 1'b0);
        chk("rst.mid_cnt", stall_cnt, 32'd0);
        chk("rst.mid_busy", {31'd0, div_busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 5'd13, 1'b1, 5'd14, 1'b1, 5'd0, 1'b0, ALU, 1'b0, 1'b0);
        chk_ctl("rst.after", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("rst.after_cnt", stall_cnt, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
